// File: rtl/branch_info_if.sv
// Branch-info channel from the execute stage to the branch predictor.
//   o : producer side (execute stage) drives the resolved-branch fields
//   i : consumer side (predictor) samples them
// Fields:
//   pc           pc of the resolved branch
//   branch_addr  resolved target address
//   taken        branch was taken
//   branch_flag  fields are valid this cycle (instruction is a branch)
interface branch_info_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] branch_addr;
  logic                  taken;
  logic                  branch_flag;

  modport o (output pc, branch_addr, taken, branch_flag);
  modport i (input  pc, branch_addr, taken, branch_flag);
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Answers next-PC predictions to fetch combinationally and is trained by
// resolved branches through a one-stage registered update pipeline.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   binfo        resolved-branch channel, consumer side (branch_info_if.i)
//   flush        invalidate the whole table and drop any pending update
//   fetch_pc     fetch-stage lookup address (pc[1:0] ignored)
//   pred_hit     valid entry with matching tag
//   pred_taken   pred_hit & counter msb
//   pred_target  stored target on a hit, else 0
module btb_predictor #(
  parameter int ENTRIES    = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_info_if.i              binfo,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Table storage
  logic [ENTRIES-1:0]    valid_q;
  tag_t                  tag_mem    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_mem [ENTRIES];
  logic [1:0]            ctr_mem    [ENTRIES];

  // Update register (stage 1)
  logic                  upd_v_q;
  idx_t                  upd_idx_q;
  tag_t                  upd_tag_q;
  logic [ADDR_WIDTH-1:0] upd_target_q;
  logic                  upd_taken_q;

  // Stage-2 control
  logic       upd_hit;
  logic       alloc;
  logic       train;
  logic       ctr_we;
  logic       tgt_we;
  logic [1:0] new_ctr;

  idx_t f_idx;
  tag_t f_tag;

  // Word-aligned addresses: the byte-offset bits carry no information.
  logic unused_ok;
  assign unused_ok = &{1'b0, fetch_pc[1:0], binfo.pc[1:0]};

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[ADDR_WIDTH-1:IDX_W+2];

  // Lookup sees the table as it stood before the current edge; an update
  // sitting in the update register is deliberately not bypassed.
  always_comb begin
    pred_hit    = valid_q[f_idx] && (tag_mem[f_idx] == f_tag);
    pred_taken  = pred_hit && ctr_mem[f_idx][1];
    pred_target = pred_hit ? target_mem[f_idx] : '0;
  end

  always_comb begin
    // NOTE: every output of a combinational block is given a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    alloc   = 1'b0;
    train   = 1'b0;
    new_ctr = 2'b10;
    upd_hit = valid_q[upd_idx_q] && (tag_mem[upd_idx_q] == upd_tag_q);
    // Flush drops the pending update at the same edge it clears the table.
    if (upd_v_q && !flush) begin
      alloc = !upd_hit && upd_taken_q;   // not-taken misses never allocate
      train = upd_hit;
    end
    if (train) begin
      new_ctr = upd_taken_q ? sat_inc(ctr_mem[upd_idx_q])
                            : sat_dec(ctr_mem[upd_idx_q]);
    end
    ctr_we = alloc || train;
    tgt_we = ctr_we && upd_taken_q;
  end

  // NOTE: sequential state is written with non-blocking assignments so all
  // registers update together at the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      upd_v_q <= 1'b0;
    end else begin
      upd_v_q <= binfo.branch_flag && !flush;
      if (flush) begin
        valid_q <= '0;
      end else if (alloc) begin
        valid_q[upd_idx_q] <= 1'b1;
      end
    end
  end

  // NOTE: tags, targets, counters and the update payload are left unreset:
  // valid_q and upd_v_q gate every use, and resetless arrays map onto RAM.
  always_ff @(posedge clk) begin
    if (binfo.branch_flag) begin
      upd_idx_q    <= binfo.pc[IDX_W+1:2];
      upd_tag_q    <= binfo.pc[ADDR_WIDTH-1:IDX_W+2];
      upd_target_q <= binfo.branch_addr;
      upd_taken_q  <= binfo.taken;
    end
    if (ctr_we) ctr_mem[upd_idx_q]    <= new_ctr;
    if (tgt_we) target_mem[upd_idx_q] <= upd_target_q;
    if (alloc)  tag_mem[upd_idx_q]    <= upd_tag_q;
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (ENTRIES=16, ADDR_WIDTH=32).
// Each table row is one clock cycle: inputs applied after an edge, the
// combinational prediction checked mid-cycle, then the next edge.
module tb_btb_predictor;

  localparam logic [31:0] PC_A = 32'h1C00_0010;  // idx 4, tag 0
  localparam logic [31:0] PC_B = 32'h1C00_0050;  // idx 4, tag 1 (aliases A)
  localparam logic [31:0] PC_C = 32'h1C00_0020;  // idx 8
  localparam logic [31:0] PC_D = 32'h1C00_0090;  // idx 4, tag 2
  localparam logic [31:0] PC_E = 32'h1C00_003C;  // idx 15
  localparam logic [31:0] PC_F = 32'h1C00_0000;  // idx 0
  localparam logic [31:0] T1   = 32'h1C00_0100;
  localparam logic [31:0] T2   = 32'h1C00_0200;
  localparam logic [31:0] T3   = 32'h1C00_0300;
  localparam logic [31:0] T4   = 32'h1C00_0500;
  localparam logic [31:0] T5   = 32'h1C00_0600;
  localparam logic [31:0] TC   = 32'h1C00_0400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] fetch_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;

  int n_checks = 0;
  int n_fail   = 0;

  branch_info_if #(.ADDR_WIDTH(32)) binfo_bus ();

  btb_predictor #(.ENTRIES(16), .ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .binfo       (binfo_bus),
    .flush       (flush),
    .fetch_pc    (fetch_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bf;
    logic [31:0] pc;
    logic [31:0] ba;
    logic        tk;
    logic        fl;
    logic [31:0] fpc;
    logic        hit;
    logic        ptk;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic bf, logic [31:0] pc, logic [31:0] ba, logic tk,
                              logic fl, logic [31:0] fpc, logic hit, logic ptk,
                              logic [31:0] tgt);
    vec_t v;
    v.bf = bf; v.pc = pc; v.ba = ba; v.tk = tk; v.fl = fl;
    v.fpc = fpc; v.hit = hit; v.ptk = ptk; v.tgt = tgt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_pred(input string name, input logic hit, input logic ptk,
                            input logic [31:0] tgt);
    check({name, "_hit"},    {31'd0, pred_hit},   {31'd0, hit});
    check({name, "_taken"},  {31'd0, pred_taken}, {31'd0, ptk});
    check({name, "_target"}, pred_target,         tgt);
  endtask

  task automatic set_inputs(input logic bf, input logic [31:0] pc, input logic [31:0] ba,
                            input logic tk, input logic fl, input logic [31:0] fpc);
    binfo_bus.branch_flag = bf;
    binfo_bus.pc          = pc;
    binfo_bus.branch_addr = ba;
    binfo_bus.taken       = tk;
    flush                 = fl;
    fetch_pc              = fpc;
  endtask

  initial begin
    // Row = {branch_flag, pc, branch_addr, taken, flush | fetch_pc, hit, taken, target}
    // Basic allocate: visible two cycles after the update cycle.
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_A, 0, 0, 0));
    vecs.push_back(mk(1, PC_A, T1, 1, 0, PC_A, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_A, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_A, 1, 1, T1));   // ctr 10
    // Three back-to-back not-taken updates: ctr 10 -> 01 -> 00 -> 00.
    vecs.push_back(mk(1, PC_A, 0,  0, 0, PC_A, 1, 1, T1));
    vecs.push_back(mk(1, PC_A, 0,  0, 0, PC_A, 1, 1, T1));
    vecs.push_back(mk(1, PC_A, 0,  0, 0, PC_A, 1, 0, T1));   // 01
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_A, 1, 0, T1));   // 00
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_A, 1, 0, T1));   // 00 saturated
    // Four taken updates with a new target: 00 -> 01 -> 10 -> 11 -> 11.
    vecs.push_back(mk(1, PC_A, T3, 1, 0, PC_A, 1, 0, T1));
    vecs.push_back(mk(1, PC_A, T3, 1, 0, PC_A, 1, 0, T1));
    vecs.push_back(mk(1, PC_A, T3, 1, 0, PC_A, 1, 0, T3));   // 01
    vecs.push_back(mk(1, PC_A, T3, 1, 0, PC_A, 1, 1, T3));   // 10
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_A, 1, 1, T3));   // 11
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_A, 1, 1, T3));   // 11 saturated
    // Aliasing: taken miss to occupied idx 4 replaces A with B.
    vecs.push_back(mk(1, PC_B, T2, 1, 0, PC_B, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_B, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_B, 1, 1, T2));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_A, 0, 0, 0));
    // Not-taken miss at an empty idx never allocates.
    vecs.push_back(mk(1, PC_C, TC, 0, 0, PC_C, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_C, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_C, 0, 0, 0));
    // Not-taken miss at an occupied idx leaves the resident entry alone.
    vecs.push_back(mk(1, PC_D, TC, 0, 0, PC_B, 1, 1, T2));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_B, 1, 1, T2));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_B, 1, 1, T2));
    // Flush the cycle after a valid update; same-cycle branch also dropped.
    vecs.push_back(mk(1, PC_C, TC, 1, 0, PC_B, 1, 1, T2));
    vecs.push_back(mk(1, PC_A, T1, 1, 1, PC_B, 1, 1, T2));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_B, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_C, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_A, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_C, 0, 0, 0));
    // Last index, and byte-offset bits ignored on lookup.
    vecs.push_back(mk(1, PC_E, T4, 1, 0, PC_E, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_E, 0, 0, 0));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_E, 1, 1, T4));
    vecs.push_back(mk(0, 0,    0,  0, 0, PC_E | 32'h3, 1, 1, T4));

    // Reset state, checked while reset is held.
    rst_n = 1'b0;
    set_inputs(0, 0, 0, 0, 0, PC_A);
    #2;
    check_pred("in_reset", 0, 0, 0);
    #10 rst_n = 1'b1;                 // released between edges
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      set_inputs(vecs[i].bf, vecs[i].pc, vecs[i].ba, vecs[i].tk, vecs[i].fl, vecs[i].fpc);
      #2;
      check_pred($sformatf("row%0d", i), vecs[i].hit, vecs[i].ptk, vecs[i].tgt);
      @(posedge clk); #1;
    end

    // Asynchronous reset with an update pending in the update register.
    set_inputs(1, PC_F, T5, 1, 0, PC_E);
    @(posedge clk); #1;               // upd_v now set for PC_F
    set_inputs(0, 0, 0, 0, 0, PC_E);
    #1;
    check_pred("pre_rst", 1, 1, T4);
    #1 rst_n = 1'b0;
    #1;
    check_pred("rst_async", 0, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    fetch_pc = PC_F;
    #1;
    check_pred("post_rst_f0", 0, 0, 0);
    @(posedge clk); #1;
    check_pred("post_rst_f1", 0, 0, 0);
    fetch_pc = PC_E;
    #1;
    check_pred("post_rst_e", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
